// File: rtl/sel_pipe_reg_if.sv
// Handshake bundle for sel_pipe_reg: channel inputs, select, valid/ready on both sides,
// plus the select-error pulse and the output transfer counter.
interface sel_pipe_reg_if #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int CW    = 16
) ();
   localparam int SW = $clog2(NCH);

   logic [NCH*WIDTH-1:0] in_data;
   logic [SW-1:0]        sel;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 sel_err;
   logic [CW-1:0]        xfer_cnt;

   // Producer/consumer side that drives the block
   modport master (
      output in_data, sel, in_valid, out_ready,
      input  in_ready, out_data, out_valid, sel_err, xfer_cnt
   );

   // The select-and-register block itself
   modport slave (
      input  in_data, sel, in_valid, out_ready,
      output in_ready, out_data, out_valid, sel_err, xfer_cnt
   );
endinterface

// File: rtl/sel_pipe_reg.sv
// N-channel select followed by a DEPTH-stage all-flop pipeline with valid/ready flow control.
// The whole pipeline either advances together or holds together; a stall happens only when
// the last stage holds a word the consumer is not taking.
module sel_pipe_reg #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int DEPTH = 2,
   parameter int CW    = 16
) (
   input  logic          clk,
   input  logic          rstn,
   sel_pipe_reg_if.slave bus
);

   logic [WIDTH-1:0] r_data [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic             r_sel_err;
   logic [CW-1:0]    r_xfer_cnt;

   logic             w_stall;
   logic             w_accept;
   logic             w_xfer;
   logic             w_sel_bad;
   logic [WIDTH-1:0] w_mux_data;

   // in_ready looks only at the output side, so there is no path from in_valid to in_ready
   assign w_stall   = r_valid[DEPTH-1] && !bus.out_ready;
   assign w_accept  = bus.in_valid && !w_stall;
   assign w_xfer    = r_valid[DEPTH-1] && bus.out_ready;
   assign w_sel_bad = int'(bus.sel) >= NCH;

   assign bus.in_ready  = !w_stall;
   assign bus.out_data  = r_data[DEPTH-1];
   assign bus.out_valid = r_valid[DEPTH-1];
   assign bus.sel_err   = r_sel_err;
   assign bus.xfer_cnt  = r_xfer_cnt;

   // Channel mux; an out-of-range select yields all-zero data
   always_comb begin
      w_mux_data = '0;
      for (int k = 0; k < NCH; k++) begin
         if (int'(bus.sel) == k) begin
            w_mux_data = bus.in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // Pipeline stages: load stage 0 from the mux, shift the rest, hold everything on stall
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= '0;
         end
         r_valid <= '0;
      end else if (!w_stall) begin
         r_data[0]  <= w_mux_data;
         r_valid[0] <= bus.in_valid;
         for (int i = 1; i < DEPTH; i++) begin
            r_data[i]  <= r_data[i-1];
            r_valid[i] <= r_valid[i-1];
         end
      end
   end

   // One-cycle error pulse on the edge that accepts a word with an invalid select
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_sel_err <= 1'b0;
      end else begin
         r_sel_err <= w_accept && w_sel_bad;
      end
   end

   // Free-running, wrapping count of completed output transfers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_xfer_cnt <= '0;
      end else if (w_xfer) begin
         r_xfer_cnt <= r_xfer_cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_sel_pipe_reg.sv
// Bench for sel_pipe_reg (NCH=3, DEPTH=2, CW=4). The reference model keeps the accepted
// words in order, each tagged with how many pipeline advances it has seen; a word is on the
// output once it has advanced DEPTH-1 times after being accepted.
module tb_sel_pipe_reg;
   localparam int WIDTH = 8;
   localparam int NCH   = 3;
   localparam int DEPTH = 2;
   localparam int CW    = 4;
   localparam int SW    = $clog2(NCH);

   logic clk = 1'b0;
   logic rstn;

   always #5 clk = ~clk;

   sel_pipe_reg_if #(.WIDTH(WIDTH), .NCH(NCH), .CW(CW)) bus ();

   sel_pipe_reg #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] chan [NCH];
   logic [WIDTH-1:0] qd [$];
   int               qa [$];
   int               exp_cnt = 0;
   logic             exp_err = 1'b0;

   function automatic bit head_vis();
      return (qa.size() > 0) && (qa[0] == DEPTH-1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check in_ready, clock, update model, check outputs
   task automatic step(input logic v, input int s, input logic r, input logic rn);
      logic [WIDTH-1:0] w;
      bit stall;
      bit vis;
      bus.in_valid  = v;
      bus.sel       = SW'(s);
      bus.out_ready = r;
      rstn          = rn;
      for (int k = 0; k < NCH; k++) bus.in_data[k*WIDTH +: WIDTH] = chan[k];
      w = (s < NCH) ? chan[s] : '0;
      #1;
      vis   = head_vis();
      stall = vis && !r;
      if (rn) chk("in_ready", 32'(bus.in_ready), 32'(!stall));
      @(posedge clk);
      if (!rn) begin
         qd.delete();
         qa.delete();
         exp_cnt = 0;
         exp_err = 1'b0;
      end else begin
         exp_err = 1'b0;
         if (!stall) begin
            if (vis) begin
               void'(qd.pop_front());
               void'(qa.pop_front());
               exp_cnt = (exp_cnt + 1) % (1 << CW);
            end
            foreach (qa[i]) qa[i]++;
            if (v) begin
               qd.push_back(w);
               qa.push_back(0);
               exp_err = (s >= NCH);
            end
         end
      end
      #1;
      vis = head_vis();
      chk("out_valid", 32'(bus.out_valid), 32'(vis));
      if (vis) chk("out_data", 32'(bus.out_data), 32'(qd[0]));
      chk("xfer_cnt", 32'(bus.xfer_cnt), 32'(exp_cnt));
      chk("sel_err", 32'(bus.sel_err), 32'(exp_err));
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.sel       = '0;
      bus.out_ready = 1'b0;
      bus.in_data   = '0;
      rstn          = 1'b0;
      chan[0] = 8'd11;
      chan[1] = 8'd22;
      chan[2] = 8'd33;

      // Reset held for two edges with in_valid high
      step(1'b1, 0, 1'b1, 1'b0);
      step(1'b1, 1, 1'b1, 1'b0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);

      // First word after release: visible DEPTH-1 edges after the accepting edge
      step(1'b1, 0, 1'b1, 1'b1);
      chk("lat_not_yet", 32'(bus.out_valid), 32'd0);
      step(1'b0, 0, 1'b1, 1'b1);
      chk("lat_first", 32'(bus.out_data), 32'd11);
      step(1'b0, 0, 1'b1, 1'b1);

      // Back-to-back stream over every channel
      for (int s = 0; s < NCH; s++) step(1'b1, s, 1'b1, 1'b1);
      step(1'b0, 0, 1'b1, 1'b1);
      step(1'b0, 0, 1'b1, 1'b1);

      // Back-pressure: fill, stall three cycles while offering words, then drain
      chan[0] = 8'hA1; chan[1] = 8'hB2; chan[2] = 8'hC3;
      step(1'b1, 0, 1'b1, 1'b1);
      step(1'b1, 1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 2, 1'b0, 1'b1);
      chk("bp_hold_data", 32'(bus.out_data), 32'hA1);
      for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b1);

      // Invalid select: accepted, zero data, one-cycle error pulse
      step(1'b1, 3, 1'b1, 1'b1);
      chk("bad_sel_pulse", 32'(bus.sel_err), 32'd1);
      step(1'b0, 0, 1'b1, 1'b1);
      chk("bad_sel_drop", 32'(bus.sel_err), 32'd0);
      chk("bad_sel_data", 32'(bus.out_data), 32'd0);
      step(1'b0, 0, 1'b1, 1'b1);

      // Reset with two words in flight
      step(1'b1, 0, 1'b1, 1'b1);
      step(1'b1, 1, 1'b1, 1'b1);
      step(1'b0, 0, 1'b1, 1'b0);
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      step(1'b0, 0, 1'b1, 1'b1);

      // Counter wrap: 17 transfers on a 4-bit counter
      step(1'b0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 19; i++) step(1'b1, i % NCH, 1'b1, 1'b1);
      chk("wrap_cnt", 32'(bus.xfer_cnt), 32'd1);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < NCH; k++) chan[k] = WIDTH'($urandom);
         step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 40) != 0);
      end
      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 0, 1'b1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
